// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Holds the controller state encoding and the iteration-counter width rule.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Counter must reach n-1; n >= 2 keeps the width at least one bit.
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/divider_seq_n_if.sv
// Start/ready/valid bundle between the controlling logic (master) and the divider (slave).
// A division is accepted on a rising edge where start_i=1 and ready_o=1; valid_o pulses once with results.
interface divider_seq_n_if #(
  parameter int nb_bit = 8
);
  logic              start_i;
  logic [nb_bit-1:0] dividend_i;
  logic [nb_bit-1:0] divisor_i;
  logic              ready_o;
  logic              valid_o;
  logic [nb_bit-1:0] quotient_o;
  logic [nb_bit-1:0] remainder_o;
  logic              div_zero_o;

  modport master (
    output start_i, dividend_i, divisor_i,
    input  ready_o, valid_o, quotient_o, remainder_o, div_zero_o
  );

  modport slave (
    input  start_i, dividend_i, divisor_i,
    output ready_o, valid_o, quotient_o, remainder_o, div_zero_o
  );
endinterface

// File: rtl/subtractor_n.sv
// Unsigned nb_bit subtractor; borrow_o=1 means a_i >= b_i (the trial subtraction succeeded).
module subtractor_n #(
  parameter int nb_bit = 9
) (
  input  logic [nb_bit-1:0] a_i,
  input  logic [nb_bit-1:0] b_i,
  output logic [nb_bit-1:0] diff_o,
  output logic              borrow_o
);
  logic [nb_bit:0] ext;

  assign ext      = {1'b0, a_i} - {1'b0, b_i};
  assign diff_o   = ext[nb_bit-1:0];
  assign borrow_o = ~ext[nb_bit];
endmodule

// File: rtl/divider_seq_n.sv
// Sequential restoring divider: one trial subtraction per clock, nb_bit iterations per division.
// Divide-by-zero short-circuits straight to DONE with quotient all ones and remainder = dividend.
module divider_seq_n
  import divider_pkg::*;
#(
  parameter int nb_bit = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  divider_seq_n_if.slave    bus,
  output div_state_t        dbg_state_o
);
  localparam int CNT_W = cnt_width(nb_bit);

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [nb_bit:0]   r_q, r_d;
  logic [nb_bit-1:0] q_q, q_d;
  logic [nb_bit-1:0] d_q, d_d;
  logic [nb_bit-1:0] quot_q, quot_d;
  logic [nb_bit-1:0] rem_q, rem_d;
  logic              dz_q, dz_d;

  logic [nb_bit:0]   trial;
  logic [nb_bit:0]   diff;
  logic              borrow;
  // R < D after every step, so the top bit of R never feeds the next trial.
  logic              unused_r_msb;

  assign trial        = {r_q[nb_bit-1:0], q_q[nb_bit-1]};
  assign unused_r_msb = r_q[nb_bit];

  subtractor_n #(.nb_bit(nb_bit + 1)) u_sub (
    .a_i      (trial),
    .b_i      ({1'b0, d_q}),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          q_d   = bus.dividend_i;
          d_d   = bus.divisor_i;
          r_d   = '0;
          cnt_d = '0;
          if (bus.divisor_i == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = bus.dividend_i;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (borrow) begin
          r_d = diff;
          q_d = {q_q[nb_bit-2:0], 1'b1};
        end else begin
          r_d = trial;
          q_d = {q_q[nb_bit-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        // Results are captured from the final step's next values, on entry to DONE.
        if (cnt_q == CNT_W'(nb_bit - 1)) begin
          state_d = DONE;
          quot_d  = q_d;
          rem_d   = r_d[nb_bit-1:0];
          dz_d    = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.ready_o     = (state_q == IDLE);
  assign bus.valid_o     = (state_q == DONE);
  assign bus.quotient_o  = quot_q;
  assign bus.remainder_o = rem_q;
  assign bus.div_zero_o  = dz_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_divider_seq_n.sv
// Directed and swept checks of divider_seq_n (nb_bit=8): latency, results, divide-by-zero,
// ignored starts, mid-division reset and back-to-back operation with start held high.
module tb_divider_seq_n;
  import divider_pkg::*;

  logic       clk;
  logic       rst_n;
  div_state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [7:0] obs_q, obs_r;
  logic       obs_dz;
  int         lat;
  bit         to;

  logic [16:0] exp_q[$];

  divider_seq_n_if #(.nb_bit(8)) bus ();

  divider_seq_n #(.nb_bit(8)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one division; lat counts rising edges after the accept edge until valid_o is seen.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.start_i    = 1'b1;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    @(negedge clk);
    bus.start_i = 1'b0;
    lat = 0;
    while (!bus.valid_o && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    to     = !bus.valid_o;
    obs_q  = bus.quotient_o;
    obs_r  = bus.remainder_o;
    obs_dz = bus.div_zero_o;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.start_i    = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    #1;
    checks++;
    if ({bus.ready_o, bus.valid_o, bus.quotient_o, bus.remainder_o, bus.div_zero_o} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b vld=%b q=%0d r=%0d dz=%b exp rdy=1 vld=0 q=0 r=0 dz=0",
               bus.ready_o, bus.valid_o, bus.quotient_o, bus.remainder_o, bus.div_zero_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_release got rdy=%b vld=%b st=%0d exp rdy=1 vld=0 st=0", bus.ready_o, bus.valid_o, dbg_state);
    end
  endtask

  task automatic test_basic();
    logic [7:0] va[4] = '{8'd200, 8'd255, 8'd5, 8'd0};
    logic [7:0] vb[4] = '{8'd7, 8'd1, 8'd9, 8'd3};
    logic [7:0] vq[4] = '{8'd28, 8'd255, 8'd0, 8'd0};
    logic [7:0] vr[4] = '{8'd4, 8'd0, 8'd5, 8'd0};
    for (int i = 0; i < 4; i++) begin
      do_div(va[i], vb[i]);
      checks++;
      if (to || lat !== 8) begin
        failures++;
        $display("FAIL basic_latency %0d/%0d got lat=%0d timeout=%0b exp lat=8", va[i], vb[i], lat, to);
      end
      checks++;
      if ({obs_q, obs_r, obs_dz} !== {vq[i], vr[i], 1'b0}) begin
        failures++;
        $display("FAIL basic_result %0d/%0d got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=0",
                 va[i], vb[i], obs_q, obs_r, obs_dz, vq[i], vr[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    do_div(8'd77, 8'd0);
    checks++;
    if (to || lat !== 0) begin
      failures++;
      $display("FAIL dz_latency got lat=%0d timeout=%0b exp lat=0", lat, to);
    end
    checks++;
    if ({obs_q, obs_r, obs_dz} !== {8'hFF, 8'd77, 1'b1}) begin
      failures++;
      $display("FAIL dz_result got q=%0d r=%0d dz=%b exp q=255 r=77 dz=1", obs_q, obs_r, obs_dz);
    end
    @(negedge clk);
    checks++;
    if (bus.div_zero_o !== 1'b1 || bus.quotient_o !== 8'hFF) begin
      failures++;
      $display("FAIL dz_hold got q=%0d dz=%b exp q=255 dz=1", bus.quotient_o, bus.div_zero_o);
    end
    do_div(8'd10, 8'd3);
    checks++;
    if (to || {obs_q, obs_r, obs_dz} !== {8'd3, 8'd1, 1'b0}) begin
      failures++;
      $display("FAIL dz_clear got q=%0d r=%0d dz=%b exp q=3 r=1 dz=0", obs_q, obs_r, obs_dz);
    end
  endtask

  task automatic test_ignore_start();
    bit rdy_seen;
    rdy_seen = 1'b0;
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.dividend_i = 8'd200;
    bus.divisor_i  = 8'd7;
    @(negedge clk);
    bus.dividend_i = 8'd100;
    bus.divisor_i  = 8'd10;
    lat = 0;
    while (!bus.valid_o && lat < 50) begin
      if (bus.ready_o) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    bus.start_i = 1'b0;
    checks++;
    if (rdy_seen || bus.valid_o !== 1'b1 || lat !== 8) begin
      failures++;
      $display("FAIL ignore_busy got rdy_seen=%0b vld=%b lat=%0d exp rdy_seen=0 vld=1 lat=8", rdy_seen, bus.valid_o, lat);
    end
    checks++;
    if ({bus.quotient_o, bus.remainder_o} !== {8'd28, 8'd4}) begin
      failures++;
      $display("FAIL ignore_result got q=%0d r=%0d exp q=28 r=4", bus.quotient_o, bus.remainder_o);
    end
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || {bus.quotient_o, bus.remainder_o} !== {8'd28, 8'd4}) begin
      failures++;
      $display("FAIL ignore_hold got vld=%b rdy=%b q=%0d r=%0d exp vld=0 rdy=1 q=28 r=4",
               bus.valid_o, bus.ready_o, bus.quotient_o, bus.remainder_o);
    end
  endtask

  task automatic test_reset_mid_calc();
    bit vld_seen;
    vld_seen = 1'b0;
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.dividend_i = 8'd200;
    bus.divisor_i  = 8'd7;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ready_o, bus.valid_o, bus.quotient_o, bus.remainder_o, bus.div_zero_o} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}
        || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL abort_outputs got rdy=%b vld=%b q=%0d r=%0d dz=%b st=%0d exp rdy=1 vld=0 q=0 r=0 dz=0 st=0",
               bus.ready_o, bus.valid_o, bus.quotient_o, bus.remainder_o, bus.div_zero_o, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.valid_o) vld_seen = 1'b1;
    end
    checks++;
    if (vld_seen) begin
      failures++;
      $display("FAIL abort_no_valid got valid_seen=1 exp valid_seen=0");
    end
    do_div(8'd9, 8'd2);
    checks++;
    if (to || {obs_q, obs_r, obs_dz} !== {8'd4, 8'd1, 1'b0}) begin
      failures++;
      $display("FAIL abort_next got q=%0d r=%0d dz=%b exp q=4 r=1 dz=0", obs_q, obs_r, obs_dz);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 616;
    logic [7:0] ca[4] = '{8'd0, 8'd1, 8'd128, 8'd255};
    logic [7:0] a, b;
    logic [16:0] got, exp;
    int idx, cyc;
    idx = 0;
    cyc = 0;
    @(negedge clk);
    while ((idx < N || exp_q.size() > 0) && cyc < 20000) begin
      if (bus.valid_o) begin
        got = {bus.quotient_o, bus.remainder_o, bus.div_zero_o};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected got q=%0d r=%0d exp no result", got[16:9], got[8:1]);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL b2b_result got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b",
                     got[16:9], got[8:1], got[0], exp[16:9], exp[8:1], exp[0]);
          end
        end
      end
      if (bus.ready_o) begin
        if (idx < N) begin
          if (idx < 16) begin
            a = ca[idx / 4];
            b = ca[idx % 4];
          end else begin
            a = 8'($urandom_range(0, 255));
            b = (idx % 2 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
          end
          bus.start_i    = 1'b1;
          bus.dividend_i = a;
          bus.divisor_i  = b;
          if (b == 8'd0) exp_q.push_back({8'hFF, a, 1'b1});
          else           exp_q.push_back({a / b, a % b, 1'b0});
          idx++;
        end else begin
          bus.start_i = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.start_i = 1'b0;
    checks++;
    if (idx != N || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain got issued=%0d pending=%0d exp issued=%0d pending=0", idx, exp_q.size(), N);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_calc();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
